// File: rtl/bp_me_cache_dma_mem.sv
// Backing-store endpoint behind an L2 slice DMA port.
// Accepts a mem_cmd header plus block_words_lp dword write beats, or issues
// block_words_lp SRAM reads, and returns a mem_resp header and read beats.
// Beats walk the block critical-word-first, wrapping inside the block.
//
// Header layout (LSB first):
//   [3:0]                      msg_type
//   [7:4]                      subop (carried, unused)
//   [8 +: paddr_width_p]       addr
//   [paddr_width_p+8 +: 3]     size (carried, ignored: always a full block)
//   [paddr_width_p+11 +: ...]  payload (zeroed in the response)
module bp_me_cache_dma_mem #(
  parameter int paddr_width_p               = 40,
  parameter int cce_block_width_p           = 512,
  localparam int cce_mem_msg_header_width_lp = paddr_width_p + 24,
  localparam int block_words_lp              = cce_block_width_p / 64,
  localparam int mem_addr_width_lp           = paddr_width_p - 3
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
  input  logic                                   mem_cmd_header_v_i,
  output logic                                   mem_cmd_header_yumi_o,
  input  logic [63:0]                            mem_cmd_data_i,
  input  logic                                   mem_cmd_data_v_i,
  output logic                                   mem_cmd_data_yumi_o,

  output logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
  output logic                                   mem_resp_header_v_o,
  input  logic                                   mem_resp_header_ready_i,
  output logic [63:0]                            mem_resp_data_o,
  output logic                                   mem_resp_data_v_o,
  input  logic                                   mem_resp_data_ready_i,

  output logic                                   sram_v_o,
  output logic                                   sram_w_o,
  output logic [mem_addr_width_lp-1:0]           sram_addr_o,
  output logic [63:0]                            sram_data_o,
  input  logic [63:0]                            sram_data_i
);

  localparam int hdr_w_lp          = cce_mem_msg_header_width_lp;
  localparam int lg_block_words_lp = $clog2(block_words_lp);
  localparam int lg_block_bytes_lp = $clog2(cce_block_width_p / 8);
  localparam int cnt_width_lp      = lg_block_words_lp + 1;
  localparam int addr_lsb_lp       = 8;
  localparam int payload_lsb_lp    = paddr_width_p + 11;

  localparam logic [3:0] e_bedrock_mem_wr = 4'b0001;
  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(block_words_lp - 1);
  localparam logic [hdr_w_lp-1:0] payload_mask_lp =
    {{(hdr_w_lp - payload_lsb_lp){1'b1}}, {payload_lsb_lp{1'b0}}};

  typedef enum logic [2:0] {
    e_idle       = 3'd0,
    e_write      = 3'd1,
    e_write_resp = 3'd2,
    e_read       = 3'd3,
    e_read_drain = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic [hdr_w_lp-1:0]       hdr_q, hdr_d;
  logic                      hdr_sent_q, hdr_sent_d;
  logic                      rd_inflight_q;

  logic [1:0]                fifo_cnt_q, fifo_cnt_d;
  logic                      fifo_rptr_q, fifo_wptr_q;
  logic [63:0]               fifo_mem_q [2];

  logic                      header_yumi_s;
  logic                      data_yumi_s;
  logic                      sram_v_s;
  logic                      sram_w_s;
  logic                      rd_issue_s;
  logic                      resp_hdr_v_s;
  logic                      fifo_nonempty_s;
  logic                      resp_data_v_s;
  logic [63:0]               resp_data_s;
  logic                      fifo_push_s;
  logic                      fifo_pop_s;
  logic [2:0]                occupancy_s;
  logic [paddr_width_p-1:0]  addr_s;
  logic [lg_block_words_lp-1:0] word_idx_s;

  // Beat address: block base from the latched address, word index wraps in-block.
  always_comb begin
    addr_s     = hdr_q[addr_lsb_lp +: paddr_width_p];
    word_idx_s = addr_s[lg_block_bytes_lp-1:3] + cnt_q[lg_block_words_lp-1:0];
  end

  // Read-return buffer: FIFO head, or the SRAM return directly when the FIFO is empty.
  always_comb begin
    fifo_nonempty_s = (fifo_cnt_q != 2'd0);
    resp_data_v_s   = fifo_nonempty_s | rd_inflight_q;
    resp_data_s     = fifo_nonempty_s ? fifo_mem_q[fifo_rptr_q] : sram_data_i;
    fifo_pop_s      = fifo_nonempty_s & mem_resp_data_ready_i;
    fifo_push_s     = rd_inflight_q & (fifo_nonempty_s | ~mem_resp_data_ready_i);
    occupancy_s     = {1'b0, fifo_cnt_q} + {2'b00, rd_inflight_q};
    case ({fifo_push_s, fifo_pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Command FSM: next state, beat counter, header tracking and SRAM strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hdr_d         = hdr_q;
    hdr_sent_d    = hdr_sent_q;
    header_yumi_s = 1'b0;
    data_yumi_s   = 1'b0;
    sram_v_s      = 1'b0;
    sram_w_s      = 1'b0;
    rd_issue_s    = 1'b0;
    resp_hdr_v_s  = 1'b0;
    case (state_q)
      e_idle: begin
        header_yumi_s = mem_cmd_header_v_i & reset_n_i;
        if (header_yumi_s) begin
          hdr_d      = mem_cmd_header_i & ~payload_mask_lp;
          cnt_d      = '0;
          hdr_sent_d = 1'b0;
          if (mem_cmd_header_i[3:0] == e_bedrock_mem_wr) begin
            state_d = e_write;
          end else begin
            state_d = e_read;
          end
        end else begin
          state_d = e_idle;
        end
      end
      e_write: begin
        if (mem_cmd_data_v_i) begin
          data_yumi_s = 1'b1;
          sram_v_s    = 1'b1;
          sram_w_s    = 1'b1;
          cnt_d       = cnt_q + cnt_width_lp'(1);
          if (cnt_q == last_beat_lp) begin
            state_d = e_write_resp;
          end else begin
            state_d = e_write;
          end
        end else begin
          state_d = e_write;
        end
      end
      e_write_resp: begin
        resp_hdr_v_s = 1'b1;
        if (mem_resp_header_ready_i) begin
          state_d = e_idle;
        end else begin
          state_d = e_write_resp;
        end
      end
      e_read: begin
        resp_hdr_v_s = ~hdr_sent_q;
        if (resp_hdr_v_s & mem_resp_header_ready_i) begin
          hdr_sent_d = 1'b1;
        end else begin
          hdr_sent_d = hdr_sent_q;
        end
        // Never let buffered plus in-flight beats exceed the 2-entry FIFO.
        if (occupancy_s < 3'd2) begin
          rd_issue_s = 1'b1;
          sram_v_s   = 1'b1;
          cnt_d      = cnt_q + cnt_width_lp'(1);
          if (cnt_q == last_beat_lp) begin
            state_d = e_read_drain;
          end else begin
            state_d = e_read;
          end
        end else begin
          state_d = e_read;
        end
      end
      e_read_drain: begin
        resp_hdr_v_s = ~hdr_sent_q;
        if (resp_hdr_v_s & mem_resp_header_ready_i) begin
          hdr_sent_d = 1'b1;
        end else begin
          hdr_sent_d = hdr_sent_q;
        end
        if (hdr_sent_d && (fifo_cnt_d == 2'd0)) begin
          state_d = e_idle;
        end else begin
          state_d = e_read_drain;
        end
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // Control state; a reset abandons any command without a partial response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_idle;
      cnt_q         <= '0;
      hdr_q         <= '0;
      hdr_sent_q    <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_q         <= hdr_d;
      hdr_sent_q    <= hdr_sent_d;
      rd_inflight_q <= rd_issue_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_cnt_q  <= 2'd0;
      fifo_rptr_q <= 1'b0;
      fifo_wptr_q <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (fifo_pop_s) begin
        fifo_rptr_q <= ~fifo_rptr_q;
      end
      if (fifo_push_s) begin
        fifo_wptr_q <= ~fifo_wptr_q;
      end
    end
  end

  // FIFO storage; contents are qualified by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (fifo_push_s) begin
      fifo_mem_q[fifo_wptr_q] <= sram_data_i;
    end
  end

  assign mem_cmd_header_yumi_o = header_yumi_s;
  assign mem_cmd_data_yumi_o   = data_yumi_s;
  assign mem_resp_header_o     = hdr_q;
  assign mem_resp_header_v_o   = resp_hdr_v_s;
  assign mem_resp_data_o       = resp_data_s;
  assign mem_resp_data_v_o     = resp_data_v_s;
  assign sram_v_o              = sram_v_s;
  assign sram_w_o              = sram_w_s;
  assign sram_addr_o           = {addr_s[paddr_width_p-1:lg_block_bytes_lp], word_idx_s};
  assign sram_data_o           = mem_cmd_data_i;

endmodule

// File: doc/bp_me_cache_dma_mem.md
# bp_me_cache_dma_mem

Backing-store endpoint directly downstream of the L2 cache slice's DMA port. Consumes the slice's mem_cmd header and per-dword data streams, performs block-sized writes or reads against a single-port synchronous SRAM, and returns a mem_resp header plus read-data beats. Used as the memory behind each L2 slice in simulation and FPGA configurations.

## Interface
- bp_params_p, e_bp_default_cfg: supplies paddr_width_p, cce_block_width_p, and the header width cce_mem_msg_header_width_lp.
- block_words_lp, cce_block_width_p/64: dword beats per command.
- mem_addr_width_lp, paddr_width_p-3: SRAM dword address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- mem_cmd_header_i  in  cce_mem_msg_header_width_lp  bp_bedrock_cce_mem_msg_header_s.
- mem_cmd_header_v_i  in  1  header valid.
- mem_cmd_header_yumi_o  out  1  header consumed.
- mem_cmd_data_i  in  64  write-data beat.
- mem_cmd_data_v_i  in  1  beat valid.
- mem_cmd_data_yumi_o  out  1  beat consumed.
- mem_resp_header_o  out  cce_mem_msg_header_width_lp  response header.
- mem_resp_header_v_o  out  1  response header valid.
- mem_resp_header_ready_i  in  1  downstream ready.
- mem_resp_data_o  out  64  read-data beat.
- mem_resp_data_v_o  out  1  beat valid.
- mem_resp_data_ready_i  in  1  downstream ready.
- sram_v_o  out  1  SRAM access this cycle.
- sram_w_o  out  1  write (1) / read (0).
- sram_addr_o  out  mem_addr_width_lp  dword address.
- sram_data_o  out  64  write data; full-dword mask.
- sram_data_i  in  64  read data, valid the cycle after a read.

## Operation
- Header is latched with yumi only in e_idle. Latched fields are msg_type and addr. size is ignored; every command is exactly block_words_lp beats.
- Beat address = {addr[paddr-1:log2(block bytes)], (addr word index + beat) mod block_words_lp}. The beat index wraps within the block, so critical-word-first order is preserved.
- msg_type == e_bedrock_mem_wr selects a write. Every other type is treated as a read.
- The response header echoes the latched header with payload zeroed.
- FSM states: e_idle, e_write, e_write_resp, e_read, e_read_drain.
  - e_idle: yumi on header_v_i. Go to e_write or e_read.
  - e_write: each cycle that data_v_i is high, assert data_yumi_o and perform an SRAM write in the same cycle, then increment the beat counter. After the last beat, go to e_write_resp.
  - e_write_resp: hold resp_header_v_o until ready_i, then go to e_idle.
  - e_read: resp_header_v_o is asserted on entry and held until ready_i, independent of data. Issue one SRAM read per cycle while beats remain and (buffer occupancy + reads in flight) < 2. After the last read issues, go to e_read_drain.
  - e_read_drain: wait until the header has been sent and the buffer is empty, then go to e_idle.
- Read data lands in a 2-entry FIFO. mem_resp_data_o/v_o come from the FIFO head, and a beat pops on v_o & ready_i.
- Beat counter width is log2(block_words_lp)+1. It clears on entry to e_write or e_read.

## Timing
- Reset (asynchronous, reset_n_i = 0): FSM to e_idle, counters 0, FIFO empty.
  - All of these outputs are 0 immediately: *_yumi_o, *_v_o, sram_v_o, sram_w_o.
  - Any command in progress is abandoned and no partial response is issued.
- Header yumi is combinational: in e_idle, yumi_o = header_v_i.
- First write beat can be consumed the cycle after the header yumi.
- Write response header is valid the cycle after the last beat.
- Read latency: header accepted at t, first SRAM read at t+1, first data_v_o at t+2.
- Read throughput is one beat per cycle with ready_i held high.
- ready_i low causes no data loss. Reads throttle once occupancy + in-flight reaches 2.
- A FIFO pop and an SRAM return in the same cycle are legal and keep occupancy constant.
- Data beats arriving while not in e_write are not consumed.
- A new header is not accepted until e_idle; back-to-back commands have one idle cycle between them.

## Test plan
- Write: header wr addr 0x8000_0000 plus 8 beats 0x0..0x7 presented continuously.
  - SRAM writes at dword addr 0x1000_0000..+7 on consecutive cycles.
  - One resp header wr follows, valid the cycle after the last beat.
- Read with ready_i high: header rd addr 0x8000_0000.
  - 8 beats returned on consecutive cycles starting at t+2, matching the prior write.
- Wrap: read addr 0x8000_0028.
  - Returned order is words 5,6,7,0,1,2,3,4 of the block.
- Backpressure: ready_i toggles 1-0-0-1 randomly over 8 beats.
  - All 8 beats are delivered in order with no duplicates.
  - sram reads never exceed occupancy + in-flight = 2.
  - The header is held until ready.
- Data stall: write with data_v_i gapped every other cycle.
  - Exactly 8 SRAM writes occur, at the correct addresses.
- Reset mid-read: assert reset_n_i low after 3 beats.
  - All valids drop immediately.
  - After release, a fresh read returns a complete 8-beat block.
